// File: rtl/eject_collector_pkg.sv
// Shared flit-format definitions for the node eject path: field positions,
// width helpers and port indexing used by router, node and eject collector.
package eject_collector_pkg;

   localparam int NumPorts     = 6;
   localparam int FlitOverhead = 50;

   typedef logic [2:0] port_idx_t;

   function automatic int flit_child_width(input int payload_width, input int lg_numprocs);
      return payload_width + FlitOverhead + lg_numprocs;
   endfunction

   function automatic int valid_bit_pos(input int payload_width);
      return payload_width + 49;
   endfunction

   function automatic int reduction_bit_pos(input int payload_width);
      return payload_width + 3;
   endfunction

   // Reduction-special flits are owned by the reduction FIFOs, not this path
   function automatic logic is_reduction_special(input logic [1:0] op_pair);
      return (op_pair == 2'b11);
   endfunction

   function automatic port_idx_t next_port(input port_idx_t p);
      return (p >= 3'd5) ? 3'd0 : p + 3'd1;
   endfunction

endpackage

// File: rtl/eject_collector_if.sv
// Application-side output stream of the eject collector (valid/ready).
interface eject_collector_if
   import eject_collector_pkg::*;
#(
   parameter int Width = 85
);
   logic [Width-1:0] out_flit;
   logic             out_valid;
   logic             out_ready;
   port_idx_t        out_port;

   modport master (output out_flit, output out_valid, output out_port, input out_ready);
   modport slave  (input out_flit, input out_valid, input out_port, output out_ready);
endinterface

// File: rtl/eject_port_queue.sv
// Per-port synchronous FIFO; power-of-two depth so pointers wrap naturally.
module eject_port_queue #(
   parameter int Width   = 85,
   parameter int Depth   = 4,
   parameter int LgDepth = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [Width-1:0] head
);

   logic [Width-1:0]   mem_r [Depth];
   logic [LgDepth-1:0] wr_ptr_r;
   logic [LgDepth-1:0] rd_ptr_r;
   logic [LgDepth:0]   count_r;
   logic               pop_ok_s;
   logic               push_ok_s;

   assign full      = (count_r == (LgDepth+1)'(Depth));
   assign empty     = (count_r == '0);
   assign head      = mem_r[rd_ptr_r];
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop_ok_s);

   // Storage array, written at the tail
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + LgDepth'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + LgDepth'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (LgDepth+1)'(1);
            2'b01:   count_r <= count_r - (LgDepth+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/eject_collector.sv
// Merges the six router eject streams into one registered valid/ready stream
// with per-port buffering, round-robin arbitration and overflow accounting.
module eject_collector
   import eject_collector_pkg::*;
#(
   parameter int lg_numprocs  = 3,
   parameter int PayloadWidth = 32,
   parameter int QDepth       = 4,
   parameter int LgQDepth     = 2,
   localparam int FlitChildWidth = flit_child_width(PayloadWidth, lg_numprocs)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [FlitChildWidth-1:0] eject_xpos,
   input  logic [FlitChildWidth-1:0] eject_ypos,
   input  logic [FlitChildWidth-1:0] eject_zpos,
   input  logic [FlitChildWidth-1:0] eject_xneg,
   input  logic [FlitChildWidth-1:0] eject_yneg,
   input  logic [FlitChildWidth-1:0] eject_zneg,
   input  logic                      eject_xpos_valid,
   input  logic                      eject_ypos_valid,
   input  logic                      eject_zpos_valid,
   input  logic                      eject_xneg_valid,
   input  logic                      eject_yneg_valid,
   input  logic                      eject_zneg_valid,
   eject_collector_if.master         out_if,
   output logic [15:0]               drop_count,
   output logic [5:0]                overflow
);

   localparam int RedPos = reduction_bit_pos(PayloadWidth);

   logic [FlitChildWidth-1:0] flit_s [NumPorts];
   logic [FlitChildWidth-1:0] head_s [NumPorts];
   logic [NumPorts-1:0]       valid_s;
   logic [NumPorts-1:0]       accept_s;
   logic [NumPorts-1:0]       push_s;
   logic [NumPorts-1:0]       pop_s;
   logic [NumPorts-1:0]       drop_s;
   logic [NumPorts-1:0]       full_s;
   logic [NumPorts-1:0]       empty_s;
   port_idx_t                 rr_start_s;
   port_idx_t                 winner_s;
   logic [3:0]                cand_s;
   logic                      any_ready_s;
   logic                      load_s;
   logic [2:0]                drop_total_s;
   logic [16:0]               drop_sum_s;

   logic [FlitChildWidth-1:0] out_flit_r;
   logic                      out_valid_r;
   port_idx_t                 out_port_r;
   port_idx_t                 rr_ptr_r;
   logic [15:0]               drop_count_r;
   logic [5:0]                overflow_r;

   assign flit_s[0] = eject_xpos;
   assign flit_s[1] = eject_ypos;
   assign flit_s[2] = eject_zpos;
   assign flit_s[3] = eject_xneg;
   assign flit_s[4] = eject_yneg;
   assign flit_s[5] = eject_zneg;
   assign valid_s   = {eject_zneg_valid, eject_yneg_valid, eject_xneg_valid,
                       eject_zpos_valid, eject_ypos_valid, eject_xpos_valid};

   assign load_s = !out_valid_r || out_if.out_ready;

   // Accept, enqueue or drop each incoming flit; a same-cycle pop frees a full slot
   always_comb begin
      accept_s = '0;
      push_s   = '0;
      drop_s   = '0;
      for (int p = 0; p < NumPorts; p++) begin
         accept_s[p] = valid_s[p] && !is_reduction_special(flit_s[p][RedPos -: 2]);
         push_s[p]   = accept_s[p] && (!full_s[p] || pop_s[p]);
         drop_s[p]   = accept_s[p] && full_s[p] && !pop_s[p];
      end
   end

   // Round-robin search for the first non-empty queue from rr_ptr upward
   always_comb begin
      winner_s    = '0;
      any_ready_s = 1'b0;
      cand_s      = '0;
      rr_start_s  = (rr_ptr_r > 3'd5) ? 3'd0 : rr_ptr_r;
      for (int i = 0; i < NumPorts; i++) begin
         cand_s = {1'b0, rr_start_s} + 4'(i);
         if (cand_s >= 4'd6) begin
            cand_s = cand_s - 4'd6;
         end else begin
            cand_s = cand_s;
         end
         if (!any_ready_s && !empty_s[cand_s[2:0]]) begin
            any_ready_s = 1'b1;
            winner_s    = cand_s[2:0];
         end else begin
            any_ready_s = any_ready_s;
         end
      end
   end

   // Pop the winning queue only when the output register is loading
   always_comb begin
      pop_s = '0;
      if (load_s && any_ready_s) begin
         pop_s[winner_s] = 1'b1;
      end else begin
         pop_s = '0;
      end
   end

   // Total drops this cycle, widened so saturation can be detected
   always_comb begin
      drop_total_s = '0;
      for (int p = 0; p < NumPorts; p++) begin
         drop_total_s = drop_total_s + {2'b00, drop_s[p]};
      end
      drop_sum_s = {1'b0, drop_count_r} + {14'd0, drop_total_s};
   end

   for (genvar p = 0; p < NumPorts; p++) begin : g_queue
      eject_port_queue #(
         .Width   (FlitChildWidth),
         .Depth   (QDepth),
         .LgDepth (LgQDepth)
      ) u_queue (
         .clk   (clk),
         .rst   (rst),
         .push  (push_s[p]),
         .pop   (pop_s[p]),
         .din   (flit_s[p]),
         .full  (full_s[p]),
         .empty (empty_s[p]),
         .head  (head_s[p])
      );
   end

   // Output register, round-robin pointer and overflow accounting
   always_ff @(posedge clk) begin
      if (rst) begin
         out_flit_r   <= '0;
         out_valid_r  <= 1'b0;
         out_port_r   <= 3'd0;
         rr_ptr_r     <= 3'd0;
         drop_count_r <= 16'd0;
         overflow_r   <= 6'd0;
      end else begin
         if (load_s) begin
            if (any_ready_s) begin
               out_flit_r  <= head_s[winner_s];
               out_port_r  <= winner_s;
               out_valid_r <= 1'b1;
               rr_ptr_r    <= next_port(winner_s);
            end else begin
               out_valid_r <= 1'b0;
            end
         end
         drop_count_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
         overflow_r   <= overflow_r | drop_s;
      end
   end

   assign out_if.out_flit  = out_flit_r;
   assign out_if.out_valid = out_valid_r;
   assign out_if.out_port  = out_port_r;
   assign drop_count       = drop_count_r;
   assign overflow         = overflow_r;

endmodule

// File: tb/tb_eject_collector.sv
// Directed self-checking bench for eject_collector with an in-order scoreboard.
module tb_eject_collector;
   import eject_collector_pkg::*;

   localparam int PW    = 32;
   localparam int LGN   = 3;
   localparam int FW    = flit_child_width(PW, LGN);
   localparam int OpLsb = PW;

   typedef struct {
      port_idx_t     port;
      logic [FW-1:0] flit;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [FW-1:0] ej   [NumPorts];
   logic          ej_v [NumPorts];
   logic [15:0]   drop_count;
   logic [5:0]    overflow;

   exp_t          sb_q [$];
   logic          sb_en;
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [FW-1:0] first_flit;
   logic [FW-1:0] f;

   eject_collector_if #(.Width(FW)) out_if ();

   eject_collector dut (
      .clk              (clk),
      .rst              (rst),
      .eject_xpos       (ej[0]),
      .eject_ypos       (ej[1]),
      .eject_zpos       (ej[2]),
      .eject_xneg       (ej[3]),
      .eject_yneg       (ej[4]),
      .eject_zneg       (ej[5]),
      .eject_xpos_valid (ej_v[0]),
      .eject_ypos_valid (ej_v[1]),
      .eject_zpos_valid (ej_v[2]),
      .eject_xneg_valid (ej_v[3]),
      .eject_yneg_valid (ej_v[4]),
      .eject_zneg_valid (ej_v[5]),
      .out_if           (out_if.master),
      .drop_count       (drop_count),
      .overflow         (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [FW-1:0] make_flit(input logic [3:0] op);
      logic [FW-1:0] r;
      r = FW'({$urandom(), $urandom(), $urandom()});
      r[OpLsb +: 4] = op;
      return r;
   endfunction

   // Compare any handshake about to complete, then advance one clock
   task automatic step();
      exp_t e;
      if (sb_en && out_if.out_valid && out_if.out_ready) begin
         check("sb_nonempty", FW'(sb_q.size() != 0), FW'(1'b1));
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("out_port", FW'(out_if.out_port), FW'(e.port));
            check("out_flit", out_if.out_flit, e.flit);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int p, input logic [FW-1:0] fl, input logic expect_out);
      exp_t e;
      ej[p]   = fl;
      ej_v[p] = 1'b1;
      if (expect_out) begin
         e.port = port_idx_t'(p);
         e.flit = fl;
         sb_q.push_back(e);
      end
   endtask

   task automatic clear_ej();
      for (int p = 0; p < NumPorts; p++) begin
         ej_v[p] = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_ej();
      step();
      rst = 1'b0;
      sb_q.delete();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, FW'(out_if.out_valid), FW'(1'b0));
      check({tag, "_flit"},  out_if.out_flit, FW'(1'b0));
      check({tag, "_port"},  FW'(out_if.out_port), FW'(3'd0));
      check({tag, "_drop"},  FW'(drop_count), FW'(16'd0));
      check({tag, "_ovf"},   FW'(overflow), FW'(6'd0));
   endtask

   initial begin
      rst   = 1'b1;
      sb_en = 1'b1;
      out_if.out_ready = 1'b0;
      for (int p = 0; p < NumPorts; p++) begin
         ej[p]   = '0;
         ej_v[p] = 1'b0;
      end
      step();
      step();
      rst = 1'b0;
      check_reset_state("reset");

      // Single flit on ypos: 2-cycle latency, one-cycle valid
      out_if.out_ready = 1'b1;
      f = make_flit(4'b0001);
      drive(1, f, 1'b1);
      step();
      clear_ej();
      check("lat_e0_valid", FW'(out_if.out_valid), FW'(1'b0));
      step();
      check("lat_e1_valid", FW'(out_if.out_valid), FW'(1'b1));
      check("lat_e1_port",  FW'(out_if.out_port), FW'(3'd1));
      check("lat_e1_flit",  out_if.out_flit, f);
      step();
      check("lat_e2_valid", FW'(out_if.out_valid), FW'(1'b0));

      // Two full bursts: ports 0..5 on consecutive cycles, each restarting at 0
      do_reset();
      for (int b = 0; b < 2; b++) begin
         for (int p = 0; p < NumPorts; p++) begin
            drive(p, make_flit(4'(p)), 1'b1);
         end
         step();
         clear_ej();
         for (int c = 0; c < 7; c++) begin
            step();
         end
         check("burst_drained", FW'(sb_q.size()), FW'(0));
         check("burst_idle",    FW'(out_if.out_valid), FW'(1'b0));
      end

      // Reduction-special flit is ignored entirely
      drive(5, make_flit(4'b1100), 1'b0);
      step();
      clear_ej();
      for (int c = 0; c < 3; c++) begin
         step();
      end
      check("special_valid", FW'(out_if.out_valid), FW'(1'b0));
      check("special_drop",  FW'(drop_count), FW'(16'd0));
      check("special_ovf",   FW'(overflow), FW'(6'd0));

      // Backpressure: 4 queued + 1 registered, 6th flit drops
      out_if.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         f = make_flit(4'b0010);
         if (i == 0) begin
            first_flit = f;
         end
         drive(0, f, (i < 5));
         step();
         clear_ej();
         if (i >= 1) begin
            check("hold_flit", out_if.out_flit, first_flit);
         end
      end
      check("bp_drop",  FW'(drop_count), FW'(16'd1));
      check("bp_ovf",   FW'(overflow), FW'(6'b000001));
      check("bp_valid", FW'(out_if.out_valid), FW'(1'b1));
      check("bp_port",  FW'(out_if.out_port), FW'(3'd0));
      for (int c = 0; c < 3; c++) begin
         step();
      end
      check("bp_hold_flit", out_if.out_flit, first_flit);
      check("bp_hold_drop", FW'(drop_count), FW'(16'd1));
      out_if.out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         step();
      end
      check("bp_drained", FW'(sb_q.size()), FW'(0));

      // Saturating drop counter, then reset mid-burst
      do_reset();
      check_reset_state("reset2");
      sb_en = 1'b0;
      out_if.out_ready = 1'b0;
      for (int p = 0; p < NumPorts; p++) begin
         drive(p, make_flit(4'b0000), 1'b0);
      end
      for (int c = 0; c < 10; c++) begin
         step();
      end
      check("sat_early_drop", FW'(drop_count), FW'(16'd35));
      check("sat_early_ovf",  FW'(overflow), FW'(6'b111111));
      for (int c = 0; c < 10930; c++) begin
         step();
      end
      check("sat_drop", FW'(drop_count), FW'(16'hFFFF));
      out_if.out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
      end
      check("sat_hold",   FW'(drop_count), FW'(16'hFFFF));
      check("mid_valid",  FW'(out_if.out_valid), FW'(1'b1));
      rst = 1'b1;
      step();
      check_reset_state("midrst");
      rst = 1'b0;
      clear_ej();
      for (int c = 0; c < 3; c++) begin
         step();
      end
      check("post_rst_valid", FW'(out_if.out_valid), FW'(1'b0));
      check("post_rst_drop",  FW'(drop_count), FW'(16'd0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/eject_collector.md
# eject_collector

Downstream of the node's router eject ports: merges the six `eject_*` streams into one application-side stream with valid/ready flow control. Reduction-special flits (op bits `[ReductionBitPos:ReductionBitPos-1] == 2'b11`) belong to the node's reduction FIFOs and are ignored here. Every other valid flit is buffered per port, then round-robin arbitrated onto a single registered output. The router eject path has no backpressure, so overflow is counted, not stalled.

## Interface
Parameters:
- `lg_numprocs`, 3, children-field width; `FlitChildWidth = PayloadWidth + 50 + lg_numprocs`
- `PayloadWidth`, 32, payload bits; `ValidBitPos = PayloadWidth + 49`, `ReductionBitPos = PayloadWidth + 3`
- `QDepth`, 4, entries per port queue, power of two ≥ 2
- `LgQDepth`, 2, log2(`QDepth`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `eject_xpos`, `eject_ypos`, `eject_zpos`, `eject_xneg`, `eject_yneg`, `eject_zneg`  in  `FlitChildWidth` each  router eject flits (port index 0..5 in this order)
- `eject_xpos_valid` … `eject_zneg_valid`  in  1 each  eject strobes
- `out_flit`  out  `FlitChildWidth`  selected flit, unmodified
- `out_valid`  out  1  `out_flit` holds a flit
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready`
- `out_port`  out  3  source port index (0..5) of `out_flit`
- `drop_count`  out  16  dropped-flit count, saturates at 16'hFFFF
- `overflow`  out  6  sticky per-port drop flag

## Operation
- Port p accepts when `eject_p_valid` is high and its reduction-special pair is not 2'b11. Special flits are ignored, with no counting and no flag.
- An accepted flit is written to queue p if queue p is not full, or if queue p is dequeued in the same cycle. Otherwise it is dropped: `drop_count` +1 (saturating) and `overflow[p]` set. Multiple ports dropping in one cycle add their total count, then saturate.
- Load condition: the output register is empty, or `out_valid && out_ready`. When it holds and any queue is non-empty, the winner is the first non-empty queue searching from `rr_ptr` upward, mod 6.
- On load, the winner's head goes to `out_flit`, its index to `out_port`, `out_valid` goes to 1, and that queue is popped.
- `rr_ptr` is 3 bits, reset 0, and becomes winner+1 (5 wraps to 0) on each load.
- If the load condition holds but all queues are empty, `out_valid` goes to 0. `out_flit` and `out_port` keep their last values.
- While `out_valid && !out_ready`, `out_flit`, `out_port` and `out_valid` stay stable and no queue is popped.
- Queues are FIFO in order and never reorder within a port.

## Timing
- Reset values: `out_valid` 0, `out_flit` 0, `out_port` 0, `drop_count` 0, `overflow` 0, `rr_ptr` 0, all queues empty. Reset has priority over every other event; a reset mid-operation discards all buffered flits.
- Latency, idle block: a flit sampled at edge E0 is written to its queue; `out_valid` is 1 after edge E1. Minimum latency is 2 cycles, with no combinational path from `eject_*` to outputs.
- Throughput: one flit per cycle with `out_ready` held high.
- A full queue popped and pushed in the same cycle stays full and drops nothing.
- `out_ready` has no effect while `out_valid` is 0.

## Structure
- Flit field positions (`ValidBitPos`, `ReductionBitPos`, `FlitChildWidth` formula) live in the shared flit-format package used by router and node.
- One sub-module: `eject_port_queue`, a parameterised synchronous FIFO (`push`, `pop`, `full`, `empty`, `head`), depth `QDepth`, 6 instances.
- Arbitration, the output register and the counters stay in `eject_collector`.

## Test plan
- Single flit, op bits 4'b0001, on `eject_ypos` at E0 with `out_ready` = 1: after E1, `out_valid` = 1, `out_port` = 1, `out_flit` equals the input; `out_valid` = 0 after E2.
- All six ports valid in one cycle, `out_ready` = 1: outputs appear on consecutive cycles with `out_port` = 0,1,2,3,4,5; the next simultaneous burst starts at port 0 again.
- Reduction-special flit (op[3:2] = 2'b11) on `eject_zneg`: `out_valid` stays 0, `drop_count` stays 0.
- `out_ready` = 0, 6 flits into `eject_xpos`: first 4 buffered plus 1 in the output register; 6th drops, `drop_count` = 1, `overflow` = 6'b000001, `out_flit` stable throughout.
- `drop_count` preloaded by 65540 drops: it holds 16'hFFFF. Then `rst` high for one cycle mid-burst: all outputs return to reset values the cycle after.
